// File: rtl/ecc_enc_dec_core.sv
// ecc_enc_dec_core: multi-cycle SECDED (extended Hamming) encoder/decoder.
// Supports n=8/16/32 codewords with data bits low, check bits above them
// and overall parity in the top bit.
// Optional feature macro: ECC_NOISE_EN adds the noise-injection stage
// used by the full-channel operation.
module ecc_enc_dec_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AMBA_WORD  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AMBA_WORD-1:0]  ctrl,
    input  logic [AMBA_WORD-1:0]  data_in,
    input  logic [AMBA_WORD-1:0]  codeword_width,
    input  logic [AMBA_WORD-1:0]  noise,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors,
    output logic                  busy
);

    typedef enum logic [1:0] {OpEnc = 2'b00, OpDec = 2'b01, OpFull = 2'b10, OpIllegal = 2'b11} op_e;

`ifdef ECC_NOISE_EN
    typedef enum logic [2:0] {StIdle, StEnc, StNoise, StDec, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StEnc, StDec, StDone} state_e;
`endif

    typedef struct packed {
        logic [1:0]  errs;
        logic [31:0] data;
    } dec_res_t;

    // Codeword length n; width code 11 behaves like 10
    function automatic int unsigned code_n(input logic [1:0] w);
        unique case (w)
            2'b00:   return 8;
            2'b01:   return 16;
            default: return 32;
        endcase
    endfunction

    // Number of Hamming check bits m
    function automatic int unsigned code_m(input logic [1:0] w);
        unique case (w)
            2'b00:   return 3;
            2'b01:   return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] low_mask(input int unsigned bits);
        return 32'((64'd1 << bits) - 64'd1);
    endfunction

    // XOR of the Hamming positions of every set data bit; bit i-1 of the
    // result is check bit Ci
    function automatic logic [4:0] check_vec(input logic [31:0] d, input int unsigned n);
        logic [4:0]  acc;
        int unsigned j;
        acc = '0;
        j   = 0;
        for (int unsigned pos = 3; pos < 32; pos++) begin
            if (((pos & (pos - 1)) != 0) && (pos < n)) begin
                if (d[j]) acc = acc ^ pos[4:0];
                j++;
            end
        end
        return acc;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] w);
        int unsigned n, m, k;
        logic [31:0] data, cw;
        n    = code_n(w);
        m    = code_m(w);
        k    = n - m - 1;
        data = d & low_mask(k);
        cw   = data | ((32'(check_vec(data, n)) & low_mask(m)) << k);
        cw   = cw | (32'(^cw) << (n - 1));
        return cw;
    endfunction

    function automatic dec_res_t decode(input logic [31:0] rx, input logic [1:0] w);
        int unsigned n, m, k, j;
        logic [31:0] cw, data;
        logic [4:0]  recv, syn;
        logic        perr;
        dec_res_t    res;
        n    = code_n(w);
        m    = code_m(w);
        k    = n - m - 1;
        cw   = rx & low_mask(n);
        data = cw & low_mask(k);
        recv = 5'((cw >> k) & low_mask(m));
        syn  = check_vec(data, n) ^ recv;
        perr = ^cw;
        res.errs = 2'd0;
        if (perr) begin
            if (32'(syn) > n - 1) begin
                res.errs = 2'd2;
            end else begin
                res.errs = 2'd1;
                // Syndrome names a data position: flip the matching data bit
                j = 0;
                for (int unsigned pos = 3; pos < 32; pos++) begin
                    if (((pos & (pos - 1)) != 0) && (pos < n)) begin
                        if (pos[4:0] == syn) data[j] = ~data[j];
                        j++;
                    end
                end
            end
        end else if (syn != 5'd0) begin
            res.errs = 2'd2;
        end
        res.data = data;
        return res;
    endfunction

    state_e          state_q, state_d;
    op_e             op_q;
    logic [1:0]      width_q;
    logic [31:0]     data_q;
    logic [31:0]     cw_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [1:0]      errs_q;
    logic            accept;
    logic [31:0]     enc_cw;
    dec_res_t        dec_res;
`ifdef ECC_NOISE_EN
    logic [31:0]     noise_q;
`endif

    assign accept  = (state_q == StIdle) && start && (ctrl[1:0] != 2'b11);
    assign enc_cw  = encode(data_q, width_q);
    assign dec_res = decode((op_q == OpDec) ? data_q : cw_q, width_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = (ctrl[1:0] == 2'b01) ? StDec : StEnc;
            end
            StEnc: begin
`ifdef ECC_NOISE_EN
                state_d = (op_q == OpFull) ? StNoise : StDone;
`else
                state_d = (op_q == OpFull) ? StDec : StDone;
`endif
            end
`ifdef ECC_NOISE_EN
            StNoise: state_d = StDec;
`endif
            StDec:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand latch, working codeword and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OpEnc;
            width_q    <= '0;
            data_q     <= '0;
            cw_q       <= '0;
            data_out_q <= '0;
            errs_q     <= '0;
`ifdef ECC_NOISE_EN
            noise_q    <= '0;
`endif
        end else begin
            if (accept) begin
                op_q    <= op_e'(ctrl[1:0]);
                width_q <= codeword_width[1:0];
                data_q  <= data_in[31:0];
`ifdef ECC_NOISE_EN
                noise_q <= noise[31:0];
`endif
            end
            if (state_q == StEnc) begin
                cw_q <= enc_cw;
                if (op_q == OpEnc) begin
                    data_out_q <= DATA_WIDTH'(enc_cw);
                    errs_q     <= 2'd0;
                end
            end
`ifdef ECC_NOISE_EN
            if (state_q == StNoise) begin
                cw_q <= cw_q ^ (noise_q & low_mask(code_n(width_q)));
            end
`endif
            if (state_q == StDec) begin
                data_out_q <= DATA_WIDTH'(dec_res.data);
                errs_q     <= dec_res.errs;
            end
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = errs_q;
    assign operation_done = (state_q == StDone);
    assign busy           = (state_q != StIdle);

    // Register-word bits this engine never looks at
    logic unused_bits;
`ifdef ECC_NOISE_EN
    assign unused_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};
`else
    assign unused_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2], noise};
`endif

endmodule
